// File: rtl/bsg_wormhole_traffic_test_node.sv
// Wormhole traffic node: master generates/checks credit-limited packet streams, client loops them back.
// Optional round-trip latency tracking is enabled by defining BSG_WORMHOLE_TRAFFIC_TEST_NODE_LATENCY_EN.
module bsg_wormhole_traffic_test_node #(
  parameter int flit_width_p        = 32,
  parameter int cord_width_p        = 5,
  parameter int len_width_p         = 4,
  parameter int cid_width_p         = 2,
  parameter int max_payload_flits_p = 4,
  parameter int max_outstanding_p   = 4,
  parameter int is_client_node_p    = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic [31:0]             num_packets_i,
  input  logic [cord_width_p-1:0] my_cord_i,
  input  logic [cord_width_p-1:0] dest_cord_i,
  input  logic [cid_width_p-1:0]  my_cid_i,
  input  logic [cid_width_p-1:0]  dest_cid_i,
  input  logic                    link_v_i,
  input  logic [flit_width_p-1:0] link_data_i,
  output logic                    link_ready_and_o,
  output logic                    link_v_o,
  output logic [flit_width_p-1:0] link_data_o,
  input  logic                    link_ready_and_i,
  output logic                    error_o,
  output logic [31:0]             sent_o,
  output logic [31:0]             received_o,
  output logic                    done_o,
  output logic [31:0]             max_latency_o
);

  localparam logic is_client_lp = (is_client_node_p != 0);
  localparam int   cred_w_lp    = $clog2(max_outstanding_p + 1);
  localparam int   len_lsb_lp   = cord_width_p;
  localparam int   cid_lsb_lp   = len_lsb_lp + len_width_p;
  localparam int   src_lsb_lp   = cid_lsb_lp + cid_width_p;
  localparam int   seq_lsb_lp   = src_lsb_lp + cid_width_p;
  localparam int   rep_lp       = (flit_width_p + 15) / 16;

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_BODY} tx_state_e;
  typedef enum logic       {RX_HDR, RX_BODY}          rx_state_e;

  function automatic logic [len_width_p-1:0] pkt_len(input logic [7:0] seq);
    return len_width_p'((seq % max_payload_flits_p) + 1);
  endfunction

  function automatic logic [flit_width_p-1:0] body_flit(input logic [7:0] seq, input logic [7:0] j);
    logic [rep_lp*16-1:0] wide;
    wide = {rep_lp{seq, j}};
    return wide[flit_width_p-1:0];
  endfunction

  function automatic logic [flit_width_p-1:0] make_hdr(
    input logic [cord_width_p-1:0] cord, input logic [len_width_p-1:0] len,
    input logic [cid_width_p-1:0] cid, input logic [cid_width_p-1:0] src, input logic [7:0] seq);
    logic [flit_width_p-1:0] h;
    h = '0;
    h[0 +: cord_width_p]          = cord;
    h[len_lsb_lp +: len_width_p]  = len;
    h[cid_lsb_lp +: cid_width_p]  = cid;
    h[src_lsb_lp +: cid_width_p]  = src;
    h[seq_lsb_lp +: 8]            = seq;
    return h;
  endfunction

  logic [cord_width_p-1:0] hdr_cord;
  logic [len_width_p-1:0]  hdr_len;
  logic [cid_width_p-1:0]  hdr_cid, hdr_src;
  logic [7:0]              hdr_seq;
  assign hdr_cord = link_data_i[0 +: cord_width_p];
  assign hdr_len  = link_data_i[len_lsb_lp +: len_width_p];
  assign hdr_cid  = link_data_i[cid_lsb_lp +: cid_width_p];
  assign hdr_src  = link_data_i[src_lsb_lp +: cid_width_p];
  assign hdr_seq  = link_data_i[seq_lsb_lp +: 8];

  tx_state_e               tx_state_r;
  logic [7:0]              tx_seq_r, tx_j_r;
  logic                    tx_v_r;
  logic [flit_width_p-1:0] tx_data_r;
  logic [cred_w_lp-1:0]    credits_r;
  rx_state_e               rx_state_r;
  logic [7:0]              rx_seq_r, rx_j_r;
  logic [len_width_p-1:0]  rx_len_r;
  logic                    error_r;
  logic [flit_width_p:0]   skid_r [2];
  logic                    skid_wr_r, skid_rd_r;
  logic [1:0]              skid_cnt_r;
  logic [flit_width_p:0]   skid_in, skid_head;

  logic tx_fire, rx_fire, tx_last, rx_tail, hdr_fire, start, sent_inc;
  assign skid_head        = skid_r[skid_rd_r];
  assign link_ready_and_o = is_client_lp ? (skid_cnt_r != 2'd2) : 1'b1;
  assign link_v_o         = is_client_lp ? (skid_cnt_r != 2'd0) : tx_v_r;
  assign link_data_o      = is_client_lp ? skid_head[flit_width_p-1:0] : tx_data_r;
  assign tx_fire  = link_v_o & link_ready_and_i;
  assign rx_fire  = link_v_i & link_ready_and_o;
  assign tx_last  = (tx_state_r == TX_BODY) && (tx_j_r == 8'(pkt_len(tx_seq_r)) - 8'd1);
  assign rx_tail  = (rx_state_r == RX_BODY) && (rx_j_r == 8'(rx_len_r) - 8'd1);
  assign hdr_fire = (tx_state_r == TX_HDR) && tx_fire;
  assign start    = en_i && (credits_r != '0) && ((num_packets_i == '0) || (sent_o < num_packets_i));
  assign sent_inc = tx_fire && (is_client_lp ? skid_head[flit_width_p] : tx_last);
  assign error_o  = error_r;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_state_r <= TX_IDLE;
      tx_seq_r   <= '0;
      tx_j_r     <= '0;
      tx_v_r     <= 1'b0;
      tx_data_r  <= '0;
    end else if (!is_client_lp) begin
      unique case (tx_state_r)
        TX_IDLE: if (start) begin
          tx_state_r <= TX_HDR;
          tx_v_r     <= 1'b1;
          tx_data_r  <= make_hdr(dest_cord_i, pkt_len(tx_seq_r), dest_cid_i, my_cid_i, tx_seq_r);
        end
        TX_HDR: if (tx_fire) begin
          tx_state_r <= TX_BODY;
          tx_j_r     <= '0;
          tx_data_r  <= body_flit(tx_seq_r, 8'd0);
        end
        TX_BODY: if (tx_fire) begin
          if (tx_last) begin
            tx_state_r <= TX_IDLE;
            tx_v_r     <= 1'b0;
            tx_data_r  <= '0;
            tx_seq_r   <= tx_seq_r + 8'd1;
          end else begin
            tx_j_r    <= tx_j_r + 8'd1;
            tx_data_r <= body_flit(tx_seq_r, tx_j_r + 8'd1);
          end
        end
        default: tx_state_r <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_state_r <= RX_HDR;
      rx_seq_r   <= '0;
      rx_j_r     <= '0;
      rx_len_r   <= '0;
      error_r    <= 1'b0;
    end else if (rx_fire) begin
      unique case (rx_state_r)
        RX_HDR: begin
          rx_state_r <= RX_BODY;
          rx_j_r     <= '0;
          rx_len_r   <= is_client_lp ? hdr_len : pkt_len(rx_seq_r);
          if (!is_client_lp && (hdr_cord != my_cord_i || hdr_cid != my_cid_i ||
                                hdr_seq != rx_seq_r || hdr_len != pkt_len(rx_seq_r)))
            error_r <= 1'b1;
        end
        RX_BODY: begin
          if (!is_client_lp && link_data_i != body_flit(rx_seq_r, rx_j_r))
            error_r <= 1'b1;
          if (rx_tail) begin
            rx_state_r <= RX_HDR;
            rx_seq_r   <= rx_seq_r + 8'd1;
          end else begin
            rx_j_r <= rx_j_r + 8'd1;
          end
        end
        default: rx_state_r <= RX_HDR;
      endcase
    end
  end

  // A header transfer and a tail return in the same cycle leave the credit count unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits_r  <= cred_w_lp'(max_outstanding_p);
      sent_o     <= '0;
      received_o <= '0;
      done_o     <= 1'b0;
    end else begin
      if (!is_client_lp) begin
        unique case ({hdr_fire, rx_fire && rx_tail})
          2'b10:   credits_r <= credits_r - cred_w_lp'(1);
          2'b01:   if (credits_r != cred_w_lp'(max_outstanding_p)) credits_r <= credits_r + cred_w_lp'(1);
          default: credits_r <= credits_r;
        endcase
      end
      if (sent_inc && sent_o != '1) sent_o <= sent_o + 32'd1;
      if (rx_fire && rx_tail && received_o != '1) received_o <= received_o + 32'd1;
      done_o <= !is_client_lp && (sent_o == num_packets_i) && (tx_state_r == TX_IDLE) &&
                (credits_r == cred_w_lp'(max_outstanding_p));
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    skid_in = {rx_tail, link_data_i};
    if (rx_state_r == RX_HDR)
      skid_in = {1'b0, make_hdr(dest_cord_i, hdr_len, hdr_src, my_cid_i, hdr_seq)};
  end

  // NOTE: the two skid entries are reset because the head entry drives link_data_o directly.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      skid_r[0]  <= '0;
      skid_r[1]  <= '0;
      skid_wr_r  <= 1'b0;
      skid_rd_r  <= 1'b0;
      skid_cnt_r <= '0;
    end else if (is_client_lp) begin
      if (rx_fire) begin
        skid_r[skid_wr_r] <= skid_in;
        skid_wr_r         <= ~skid_wr_r;
      end
      if (tx_fire) skid_rd_r <= ~skid_rd_r;
      unique case ({rx_fire, tx_fire})
        2'b10:   skid_cnt_r <= skid_cnt_r + 2'd1;
        2'b01:   skid_cnt_r <= skid_cnt_r - 2'd1;
        default: skid_cnt_r <= skid_cnt_r;
      endcase
    end
  end

`ifdef BSG_WORMHOLE_TRAFFIC_TEST_NODE_LATENCY_EN
  localparam int ts_ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  logic [31:0]            now_r, max_lat_r, lat;
  logic [31:0]            ts_mem_r [max_outstanding_p];
  logic [ts_ptr_w_lp-1:0] ts_wr_r, ts_rd_r;
  logic                   ts_pop;
  assign ts_pop        = !is_client_lp && rx_fire && (rx_state_r == RX_HDR) &&
                         (credits_r != cred_w_lp'(max_outstanding_p));
  assign lat           = now_r - ts_mem_r[ts_rd_r];
  assign max_latency_o = max_lat_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      now_r     <= '0;
      max_lat_r <= '0;
      ts_wr_r   <= '0;
      ts_rd_r   <= '0;
    end else begin
      now_r <= now_r + 32'd1;
      if (hdr_fire) begin
        ts_mem_r[ts_wr_r] <= now_r;
        ts_wr_r <= (ts_wr_r == ts_ptr_w_lp'(max_outstanding_p - 1)) ? '0 : ts_wr_r + ts_ptr_w_lp'(1);
      end
      if (ts_pop) begin
        ts_rd_r <= (ts_rd_r == ts_ptr_w_lp'(max_outstanding_p - 1)) ? '0 : ts_rd_r + ts_ptr_w_lp'(1);
        if (lat > max_lat_r) max_lat_r <= lat;
      end
    end
  end
`else
  assign max_latency_o = '0;
`endif

endmodule
